// File: rtl/heater_ramp_ctrl.sv
// Supervisory ramp controller for an array of heater channels: staggered enable/disable,
// per-channel settle masking and a saturating error log. Define HEATER_FAULT_STOP_EN for fault stop.
module heater_ramp_ctrl #(
  parameter int NUM_CH        = 8,
  parameter int STEP_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 8192,
  parameter int ERR_CNT_W     = 16,
  localparam int CW           = $clog2(NUM_CH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [CW-1:0]        target,
  input  logic                 clear_errs,
  input  logic [NUM_CH-1:0]    ch_error,
  output logic [NUM_CH-1:0]    ch_enable,
  output logic [NUM_CH-1:0]    ch_err_clear,
  output logic [CW-1:0]        active_cnt,
  output logic                 busy,
  output logic [NUM_CH-1:0]    err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [5:0]           first_err_ch,
  output logic                 fault
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP_UP, S_HOLD, S_RAMP_DOWN, S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          step_q, step_d;
  logic [CW-1:0]          active_q, active_d;
  logic [NUM_CH-1:0]      enable_q, enable_d;
  logic                   busy_q;
  logic [CW-1:0]          tgt, stop_cnt;
  logic [NUM_CH-1:0]      err_in_q, armed, clear_vec, e;
  logic                   e_any;
  logic [NUM_CH-1:0]      sticky_q;
  logic [ERR_CNT_W-1:0]   count_q;
  logic                   first_valid_q;
  logic [5:0]             first_ch_q;

  assign tgt      = (target > CW'(NUM_CH)) ? CW'(NUM_CH) : target;
  assign stop_cnt = run ? tgt : '0;
  assign e        = err_in_q & armed;
  assign e_any    = |e;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    step_d   = step_q;
    case (state_q)
      S_IDLE: begin
        if (run && tgt != '0) begin
          active_d = CW'(1);
          step_d   = '0;
          state_d  = S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (!run || tgt < active_q) begin
          state_d = S_RAMP_DOWN;
          step_d  = '0;
        end else if (active_q == tgt) begin
          state_d = S_HOLD;
          step_d  = '0;
        end else if (step_q == STEP_LAST) begin
          active_d = active_q + CW'(1);
          step_d   = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_HOLD: begin
        // Leaving HOLD takes its first step on the transition edge itself.
        if (run && tgt > active_q) begin
          active_d = active_q + CW'(1);
          step_d   = '0;
          state_d  = S_RAMP_UP;
        end else if (!run || tgt < active_q) begin
          active_d = active_q - CW'(1);
          step_d   = '0;
          state_d  = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (run && tgt > active_q) begin
          state_d = S_RAMP_UP;
          step_d  = '0;
        end else if (active_q == stop_cnt) begin
          state_d = (active_q == '0) ? S_IDLE : S_HOLD;
          step_d  = '0;
        end else if (step_q == STEP_LAST) begin
          active_d = active_q - CW'(1);
          step_d   = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
`ifdef HEATER_FAULT_STOP_EN
      S_FAULT: begin
        if (!run) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d  = S_IDLE;
        active_d = '0;
        step_d   = '0;
      end
    endcase
`ifdef HEATER_FAULT_STOP_EN
    if (e_any && state_q != S_FAULT) begin
      state_d  = S_FAULT;
      active_d = '0;
      step_d   = '0;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_therm
      assign enable_d[gi] = (CW'(gi) < active_d);
    end
  endgenerate

`ifdef HEATER_FAULT_STOP_EN
  logic fault_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      active_q <= '0;
      enable_q <= '0;
      busy_q   <= 1'b0;
`ifdef HEATER_FAULT_STOP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      active_q <= active_d;
      enable_q <= enable_d;
      busy_q   <= (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN) || (state_d == S_FAULT);
`ifdef HEATER_FAULT_STOP_EN
      fault_q  <= (state_d == S_FAULT);
`endif
    end
  end

  // Per-channel settle window: err_clear spans SETTLE_CYCLES from the enable edge, arm one cycle later.
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TW-1:0] settle_q;
      logic          clear_q;
      logic          armed_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          settle_q <= '0;
          clear_q  <= 1'b0;
          armed_q  <= 1'b0;
        end else if (!enable_d[gi]) begin
          settle_q <= '0;
          clear_q  <= 1'b0;
          armed_q  <= 1'b0;
        end else if (!enable_q[gi]) begin
          settle_q <= TW'(SETTLE_CYCLES);
          clear_q  <= 1'b1;
          armed_q  <= 1'b0;
        end else begin
          if (settle_q != '0) settle_q <= settle_q - TW'(1);
          clear_q <= (settle_q > TW'(1));
          armed_q <= !clear_q;
        end
      end

      assign clear_vec[gi] = clear_q;
      assign armed[gi]     = armed_q;
    end
  endgenerate

  function automatic logic [5:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 6'(i);
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_in_q      <= '0;
      sticky_q      <= '0;
      count_q       <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      err_in_q <= ch_error;
      if (clear_errs) begin
        // A same-cycle error survives the clear and restarts the log.
        sticky_q      <= e;
        count_q       <= ERR_CNT_W'(e_any);
        first_valid_q <= e_any;
        if (e_any) first_ch_q <= lowest_set(e);
      end else begin
        sticky_q <= sticky_q | e;
        if (e_any && count_q != '1) count_q <= count_q + ERR_CNT_W'(1);
        if (e_any && !first_valid_q) begin
          first_valid_q <= 1'b1;
          first_ch_q    <= lowest_set(e);
        end
      end
    end
  end

  assign ch_enable       = enable_q;
  assign ch_err_clear    = clear_vec;
  assign active_cnt      = active_q;
  assign busy            = busy_q;
  assign err_sticky      = sticky_q;
  assign err_count       = count_q;
  assign first_err_valid = first_valid_q;
  assign first_err_ch    = first_ch_q;
`ifdef HEATER_FAULT_STOP_EN
  assign fault           = fault_q;
`else
  assign fault           = 1'b0;
`endif

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// Bench for heater_ramp_ctrl: timestamp-based reference model checked every cycle, plus directed literals.
module tb_heater_ramp_ctrl;

  localparam int NCH    = 4;
  localparam int STEP   = 4;
  localparam int SETTLE = 8;
  localparam int ECW    = 4;
  localparam int CMAX   = (1 << ECW) - 1;
`ifdef HEATER_FAULT_STOP_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run = 1'b0;
  logic [2:0]     target = '0;
  logic           clear_errs = 1'b0;
  logic [NCH-1:0] ch_error = '0;
  logic [NCH-1:0] ch_enable, ch_err_clear, err_sticky;
  logic [2:0]     active_cnt;
  logic           busy, first_err_valid, fault;
  logic [ECW-1:0] err_count;
  logic [5:0]     first_err_ch;

  int checks = 0;
  int errors = 0;

  heater_ramp_ctrl #(
    .NUM_CH(NCH), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE), .ERR_CNT_W(ECW)
  ) dut (
    .clk(clk), .reset(rst), .run(run), .target(target), .clear_errs(clear_errs),
    .ch_error(ch_error), .ch_enable(ch_enable), .ch_err_clear(ch_err_clear),
    .active_cnt(active_cnt), .busy(busy), .err_sticky(err_sticky), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_ch(first_err_ch), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: modes 0 idle, 1 up, 2 hold, 3 down, 4 fault. Channels are tracked by enable timestamp.
  int             now, m_active, m_mode, m_edge;
  int             m_en[NCH];
  logic [NCH-1:0] m_err_prev, m_sticky;
  int             m_count, m_fch;
  bit             m_fvalid;

  function automatic bit m_armed(int i, int k);
    return m_en[i] >= 0 && k >= m_en[i] + SETTLE + 1;
  endfunction

  function automatic int m_clrvec(int k);
    int v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_en[i] >= 0 && k - m_en[i] < SETTLE) v |= (1 << i);
    return v;
  endfunction

  task automatic m_reset();
    now = 0; m_active = 0; m_mode = 0; m_edge = 0;
    for (int i = 0; i < NCH; i++) m_en[i] = -1;
    m_err_prev = '0; m_sticky = '0; m_count = 0; m_fch = 0; m_fvalid = 1'b0;
  endtask

  task automatic m_up();
    m_en[m_active] = now; m_active++; m_edge = now;
  endtask

  task automatic m_down();
    m_active--; m_en[m_active] = -1; m_edge = now;
  endtask

  task automatic m_step();
    int tgt, stop;
    logic [NCH-1:0] ev;
    now++;
    tgt  = (int'(target) > NCH) ? NCH : int'(target);
    stop = run ? tgt : 0;
    ev = '0;
    for (int i = 0; i < NCH; i++) ev[i] = m_err_prev[i] && m_armed(i, now - 1);
    m_err_prev = ch_error;
    if (clear_errs) begin m_sticky = '0; m_count = 0; m_fvalid = 1'b0; end
    if (ev != '0) begin
      m_sticky |= ev;
      if (m_count < CMAX) m_count++;
      if (!m_fvalid) begin
        m_fvalid = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) if (ev[i]) m_fch = i;
      end
    end
    if (FAULT_EN && ev != '0 && m_mode != 4) begin
      m_mode = 4; m_active = 0;
      for (int i = 0; i < NCH; i++) m_en[i] = -1;
    end else begin
      case (m_mode)
        0: if (run && tgt > 0) begin m_up(); m_mode = 1; end
        1: if (!run || tgt < m_active) begin m_mode = 3; m_edge = now; end
           else if (m_active == tgt) m_mode = 2;
           else if (now - m_edge == STEP) m_up();
        2: if (run && tgt > m_active) begin m_up(); m_mode = 1; end
           else if (!run || tgt < m_active) begin m_down(); m_mode = 3; end
        3: if (run && tgt > m_active) begin m_mode = 1; m_edge = now; end
           else if (m_active == stop) m_mode = (stop == 0) ? 0 : 2;
           else if (now - m_edge == STEP) m_down();
        4: if (!run) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("enable", int'(ch_enable), (1 << m_active) - 1);
      chk("active_cnt", int'(active_cnt), m_active);
      chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 3 || m_mode == 4));
      chk("err_clear", int'(ch_err_clear), m_clrvec(now));
      chk("sticky", int'(err_sticky), int'(m_sticky));
      chk("err_count", int'(err_count), m_count);
      chk("first_valid", int'(first_err_valid), int'(m_fvalid));
      if (m_fvalid) chk("first_ch", int'(first_err_ch), m_fch);
      chk("fault", int'(fault), int'(m_mode == 4));
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    chk("rst_enable", int'(ch_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(err_count), 0);
    chk("rst_active", int'(active_cnt), 0);
    cyc_wait(2);
    // Ramp up to 3 with channel 0 erroring only inside its settle window.
    rst = 1'b0; run = 1'b1; target = 3'd3; ch_error = 4'b0001;
    cyc_wait(1);
    chk("up_e0_en", int'(ch_enable), 1);
    chk("up_e0_clr", int'(ch_err_clear), 1);
    chk("up_e0_busy", int'(busy), 1);
    cyc_wait(4);
    chk("up_e4_en", int'(ch_enable), 3);
    cyc_wait(3);
    chk("up_e7_en", int'(ch_enable), 3);
    cyc_wait(1);
    chk("up_e8_en", int'(ch_enable), 7);
    chk("up_e8_clr", int'(ch_err_clear), 6);
    ch_error = 4'b0000;
    cyc_wait(1);
    chk("hold_busy", int'(busy), 0);
    chk("hold_active", int'(active_cnt), 3);
    chk("masked_count", int'(err_count), 0);
    ch_error = 4'b0001;
    cyc_wait(1);
    ch_error = 4'b0000;
    chk("pipe_count", int'(err_count), 0);
    cyc_wait(1);
    chk("armed_count", int'(err_count), 1);
`ifdef HEATER_FAULT_STOP_EN
    chk("fault_en", int'(ch_enable), 0);
    chk("fault_flag", int'(fault), 1);
    cyc_wait(3);
    chk("fault_hold", int'(fault), 1);
    run = 1'b0;
    cyc_wait(1);
    chk("fault_exit", int'(fault), 0);
    chk("fault_exit_busy", int'(busy), 0);
`else
    chk("armed_sticky", int'(err_sticky), 1);
    chk("armed_first", int'(first_err_ch), 0);
    chk("armed_fvalid", int'(first_err_valid), 1);
    cyc_wait(2);
    // Retarget above NUM_CH, then ramp down to zero.
    target = 3'd5;
    cyc_wait(1);
    chk("clamp_en", int'(ch_enable), 15);
    chk("clamp_active", int'(active_cnt), 4);
    chk("clamp_clr", int'(ch_err_clear), 12);
    cyc_wait(1);
    chk("clamp_hold", int'(busy), 0);
    run = 1'b0;
    cyc_wait(1);
    chk("dn_0", int'(ch_enable), 7);
    cyc_wait(4);
    chk("dn_1", int'(ch_enable), 3);
    cyc_wait(4);
    chk("dn_2", int'(ch_enable), 1);
    cyc_wait(4);
    chk("dn_3", int'(ch_enable), 0);
    chk("dn_3_busy", int'(busy), 1);
    cyc_wait(1);
    chk("dn_idle", int'(busy), 0);
    // Clear colliding with an armed error on channel 2.
    run = 1'b1; target = 3'd3;
    cyc_wait(20);
    ch_error = 4'b0100;
    cyc_wait(1);
    clear_errs = 1'b1; ch_error = 4'b0000;
    cyc_wait(1);
    clear_errs = 1'b0;
    chk("coll_count", int'(err_count), 1);
    chk("coll_sticky", int'(err_sticky), 4);
    chk("coll_first", int'(first_err_ch), 2);
    clear_errs = 1'b1;
    cyc_wait(1);
    clear_errs = 1'b0;
    chk("clr_count", int'(err_count), 0);
    chk("clr_fvalid", int'(first_err_valid), 0);
    // Saturation of the 4-bit counter.
    ch_error = 4'b0100;
    cyc_wait(10);
    chk("sat_mid", int'(err_count), 9);
    cyc_wait(10);
    chk("sat_top", int'(err_count), 15);
    ch_error = 4'b0000;
    cyc_wait(3);
    chk("sat_hold", int'(err_count), 15);
`endif
    // Asynchronous reset in the middle of a ramp.
    run = 1'b1; target = 3'd4;
    cyc_wait(6);
    chk("pre_rst_en", int'(ch_enable != 0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", int'(ch_enable), 0);
    chk("mid_rst_active", int'(active_cnt), 0);
    chk("mid_rst_count", int'(err_count), 0);
    chk("mid_rst_clr", int'(ch_err_clear), 0);
    cyc_wait(2);
    rst = 1'b0; run = 1'b0; target = 3'd0;
    cyc_wait(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
